fdtd_hy_sweep_ctrl: RTL and testbench

Sweep sequencer that sits directly upstream and downstream of the Hy update datapath (fdtd_calc_Hy). For one 1-D Hy update pass it:
- streams Ez[k] and Hy[k-1] from field RAMs into the datapath, aligned in time;
- drives the datapath clock enable;
- writes returned Hy_n results back to Hy RAM at the matching address.
One start pulse produces one complete pass over n_cells_i cells.

---
 rtl/fdtd_hy_sweep_ctrl_pkg.sv | 21 ++
 rtl/fdtd_valid_pipe.sv | 31 +++
 rtl/fdtd_hy_sweep_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_fdtd_hy_sweep_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_hy_sweep_ctrl_pkg.sv
// Shared types and latency helper for the FDTD Hy sweep sequencer.
package fdtd_pkg;

    // Default field sample width (two's complement).
    localparam int FDTD_DATA_WIDTH_DEF = 32;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fdtd_state_e;

    // Cycles from a read issue to the write-back of the matching Hy result:
    // RAM latency, the input register, the Hy skew and the datapath latency.
    function automatic int fdtd_wr_latency(input int rd_lat, input int hy_skew, input int calc_lat);
        return rd_lat + 1 + hy_skew + calc_lat;
    endfunction

endpackage

// File: rtl/fdtd_valid_pipe.sv
// Fixed-depth shift register with asynchronous clear. Carries {valid, addr}
// tags through the write-back path and delays Hy samples for skew alignment.
module fdtd_valid_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Advance every stage by one slot per clock; reset clears all stages.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/fdtd_hy_sweep_ctrl.sv
// Hy sweep sequencer: streams Ez[k] / Hy[k-1] into the Hy update datapath,
// gates its clock enable, and writes the returned Hy results back in order.
module fdtd_hy_sweep_ctrl
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = FDTD_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH      = 10,
    parameter int RAM_RD_LAT      = 1,
    parameter int CALC_LAT        = 4,
    parameter int HY_SKEW         = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       start_i,
    input  logic [ADDR_WIDTH-1:0]      n_cells_i,
    output logic                       ez_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      ez_rd_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0] ez_rd_data_i,
    output logic                       hy_rd_en_o,
    output logic [ADDR_WIDTH-1:0]      hy_rd_addr_o,
    input  logic [FDTD_DATA_WIDTH-1:0] hy_rd_data_i,
    output logic                       calc_clken_o,
    output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o,
    output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
    input  logic [FDTD_DATA_WIDTH-1:0] Hy_n_i,
    output logic                       hy_wr_en_o,
    output logic [ADDR_WIDTH-1:0]      hy_wr_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0] hy_wr_data_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int DW     = FDTD_DATA_WIDTH;
    localparam int AW     = ADDR_WIDTH;
    localparam int WR_LAT = fdtd_wr_latency(RAM_RD_LAT, HY_SKEW, CALC_LAT);
    // In-flight tags never exceed WR_LAT, so this width cannot overflow.
    localparam int CW     = $clog2(WR_LAT + 2);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [CW-1:0] INFL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] INFL_ONE  = CW'(1);

    fdtd_state_e     r_state;
    fdtd_state_e     w_state_next;
    logic [AW-1:0]   r_n;
    logic [AW-1:0]   w_n_next;
    logic [AW-1:0]   r_k;
    logic [AW-1:0]   w_k_next;
    logic            w_run_next;
    logic            w_hy_issue_next;

    logic            r_ez_rd_en;
    logic [AW-1:0]   r_ez_rd_addr;
    logic            r_hy_rd_en;
    logic [AW-1:0]   r_hy_rd_addr;
    logic            r_clken;
    logic            r_busy;
    logic            r_done;

    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   w_inflight_next;

    logic            w_ez_rv;
    logic            w_hy_rv;
    logic [DW-1:0]   r_ez_old;
    logic [DW-1:0]   r_hy_reg;
    logic [DW-1:0]   w_hy_skewed;

    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;

    // Next-state, pass counter and next-cycle issue decisions.
    always_comb begin
        w_state_next    = r_state;
        w_n_next        = r_n;
        w_k_next        = r_k;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (n_cells_i != ADDR_ZERO) begin
                        w_n_next     = n_cells_i;
                        w_k_next     = ADDR_ZERO;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Terminal compare before increment keeps k within AW bits.
                if (r_k == r_n) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_k_next = r_k + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                if (r_inflight == INFL_ZERO) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_run_next      = (w_state_next == ST_RUN);
        w_hy_issue_next = w_run_next && (w_k_next != ADDR_ZERO);
    end

    // Count write tags issued but not yet written back.
    always_comb begin
        w_inflight_next = r_inflight;
        if (r_hy_rd_en && !w_wr_en) begin
            w_inflight_next = r_inflight + INFL_ONE;
        end else if (!r_hy_rd_en && w_wr_en) begin
            w_inflight_next = r_inflight - INFL_ONE;
        end else begin
            w_inflight_next = r_inflight;
        end
    end

    // State, counters and registered control outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_IDLE;
            r_n          <= ADDR_ZERO;
            r_k          <= ADDR_ZERO;
            r_inflight   <= INFL_ZERO;
            r_ez_rd_en   <= 1'b0;
            r_ez_rd_addr <= ADDR_ZERO;
            r_hy_rd_en   <= 1'b0;
            r_hy_rd_addr <= ADDR_ZERO;
            r_clken      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_n          <= w_n_next;
            r_k          <= w_k_next;
            r_inflight   <= w_inflight_next;
            r_ez_rd_en   <= w_run_next;
            r_ez_rd_addr <= w_run_next ? w_k_next : ADDR_ZERO;
            r_hy_rd_en   <= w_hy_issue_next;
            r_hy_rd_addr <= w_hy_issue_next ? (w_k_next - ADDR_ONE) : ADDR_ZERO;
            // Enable stays up while issuing and until the last tag has exited.
            r_clken      <= w_run_next || (w_inflight_next != INFL_ZERO);
            r_busy       <= w_run_next || (w_state_next == ST_DRAIN);
            r_done       <= (w_state_next == ST_DONE);
        end
    end

    // Read-return tracker: marks the cycle each RAM's data is valid.
    fdtd_valid_pipe #(
        .DEPTH (RAM_RD_LAT),
        .WIDTH (2)
    ) u_rd_valid_pipe (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_d   ({r_ez_rd_en, r_hy_rd_en}),
        .o_q   ({w_ez_rv, w_hy_rv})
    );

    // Capture returned samples; hold the last value between returns.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ez_old <= {DW{1'b0}};
            r_hy_reg <= {DW{1'b0}};
        end else begin
            if (w_ez_rv) begin
                r_ez_old <= ez_rd_data_i;
            end
            if (w_hy_rv) begin
                r_hy_reg <= hy_rd_data_i;
            end
        end
    end

    generate
        if (HY_SKEW > 0) begin : g_hy_skew
            fdtd_valid_pipe #(
                .DEPTH (HY_SKEW),
                .WIDTH (DW)
            ) u_hy_skew_pipe (
                .CLK   (CLK),
                .RST_N (RST_N),
                .i_d   (r_hy_reg),
                .o_q   (w_hy_skewed)
            );
        end else begin : g_hy_noskew
            assign w_hy_skewed = r_hy_reg;
        end
    endgenerate

    // Write tag {valid, addr k-1} follows the sample through RAM, skew and datapath.
    fdtd_valid_pipe #(
        .DEPTH (WR_LAT),
        .WIDTH (AW + 1)
    ) u_wr_tag_pipe (
        .CLK   (CLK),
        .RST_N (RST_N),
        .i_d   ({r_hy_rd_en, r_hy_rd_addr}),
        .o_q   ({w_wr_en, w_wr_addr})
    );

    assign ez_rd_en_o   = r_ez_rd_en;
    assign ez_rd_addr_o = r_ez_rd_addr;
    assign hy_rd_en_o   = r_hy_rd_en;
    assign hy_rd_addr_o = r_hy_rd_addr;
    assign calc_clken_o = r_clken;
    assign Ez_old_o     = r_ez_old;
    assign Hy_old_o     = w_hy_skewed;
    assign hy_wr_en_o   = w_wr_en;
    assign hy_wr_addr_o = w_wr_addr;
    // Datapath result passes straight through; forced to zero when no write.
    assign hy_wr_data_o = w_wr_en ? Hy_n_i : {DW{1'b0}};
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_fdtd_hy_sweep_ctrl.sv
// Self-checking bench for fdtd_hy_sweep_ctrl: RAM and datapath models plus
// per-scenario tasks comparing write-back against Hy + (Ez[k+1]-Ez[k]).
module tb_fdtd_hy_sweep_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int RL   = 1;
    localparam int CL   = 4;
    localparam int SK   = 0;
    localparam int NMAX = (1 << AW) - 1;
    // Documented first-write latency from the start pulse.
    localparam int FIRST_WR = 2 + RL + 1 + SK + CL;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] n_cells_i = '0;
    logic          ez_rd_en_o, hy_rd_en_o, calc_clken_o, hy_wr_en_o, busy_o, done_o;
    logic [AW-1:0] ez_rd_addr_o, hy_rd_addr_o, hy_wr_addr_o;
    logic [DW-1:0] ez_rd_data_i, hy_rd_data_i, Ez_old_o, Hy_old_o, Hy_n_i, hy_wr_data_o;

    fdtd_hy_sweep_ctrl #(
        .FDTD_DATA_WIDTH (DW), .ADDR_WIDTH (AW), .RAM_RD_LAT (RL),
        .CALC_LAT (CL), .HY_SKEW (SK)
    ) dut (
        .CLK (CLK), .RST_N (RST_N), .start_i (start_i), .n_cells_i (n_cells_i),
        .ez_rd_en_o (ez_rd_en_o), .ez_rd_addr_o (ez_rd_addr_o), .ez_rd_data_i (ez_rd_data_i),
        .hy_rd_en_o (hy_rd_en_o), .hy_rd_addr_o (hy_rd_addr_o), .hy_rd_data_i (hy_rd_data_i),
        .calc_clken_o (calc_clken_o), .Ez_old_o (Ez_old_o), .Hy_old_o (Hy_old_o),
        .Hy_n_i (Hy_n_i), .hy_wr_en_o (hy_wr_en_o), .hy_wr_addr_o (hy_wr_addr_o),
        .hy_wr_data_o (hy_wr_data_o), .busy_o (busy_o), .done_o (done_o)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Field RAMs (contents owned by the test tasks); RL=1 registered read.
    logic [DW-1:0] ez_mem [0:NMAX];
    logic [DW-1:0] hy_mem [0:NMAX];
    always @(posedge CLK) begin
        if (ez_rd_en_o) ez_rd_data_i <= ez_mem[ez_rd_addr_o];
        if (hy_rd_en_o) hy_rd_data_i <= hy_mem[hy_rd_addr_o];
    end

    // Datapath model: Hy_n = Hy_old + (Ez - previous Ez), CL cycles later.
    logic [DW-1:0] dp [0:CL-1];
    logic [DW-1:0] dp_prev;
    always @(posedge CLK) begin
        if (calc_clken_o) begin
            dp[0]   <= Hy_old_o + Ez_old_o - dp_prev;
            dp_prev <= Ez_old_o;
            for (int i = 1; i < CL; i++) dp[i] <= dp[i-1];
        end
    end
    assign Hy_n_i = dp[CL-1];

    // Monitor: logs writes and Ez reads, counts Hy reads, done and busy cycles.
    logic [AW-1:0] wq_addr [$];
    logic [DW-1:0] wq_data [$];
    int            wq_cyc  [$];
    logic [AW-1:0] ezq     [$];
    int hrd_cnt = 0, done_cnt = 0, busy_cnt = 0;
    always @(negedge CLK) begin
        if (hy_wr_en_o) begin
            wq_addr.push_back(hy_wr_addr_o);
            wq_data.push_back(hy_wr_data_o);
            wq_cyc.push_back(cyc);
        end
        if (ez_rd_en_o) ezq.push_back(ez_rd_addr_o);
        if (hy_rd_en_o) hrd_cnt <= hrd_cnt + 1;
        if (done_o)     done_cnt <= done_cnt + 1;
        if (busy_o)     busy_cnt <= busy_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;
    int start_cyc = 0;

    function automatic logic [DW-1:0] model_hy(input int i);
        return hy_mem[i] + ez_mem[i+1] - ez_mem[i];
    endfunction

    function automatic logic any_out();
        return |{ez_rd_en_o, ez_rd_addr_o, hy_rd_en_o, hy_rd_addr_o, calc_clken_o,
                 Ez_old_o, Hy_old_o, hy_wr_en_o, hy_wr_addr_o, hy_wr_data_o, busy_o, done_o};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic kick(input int n);
        start_i   = 1'b1;
        n_cells_i = AW'(n);
        start_cyc = cyc;
        tick();
        start_i   = 1'b0;
        n_cells_i = AW'($urandom);
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i <= n; i++) begin
            ez_mem[i] = $urandom;
            hy_mem[i] = $urandom;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) tick();
        vectors++;
        if (any_out() !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: some output nonzero (or=%b) required all 0", any_out());
        end
        RST_N = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({busy_o, done_o, calc_clken_o, ez_rd_en_o, hy_rd_en_o, hy_wr_en_o} !== 6'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: ctl=%b required 000000",
                     {busy_o, done_o, calc_clken_o, ez_rd_en_o, hy_rd_en_o, hy_wr_en_o});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] ez_v [5];
        logic [DW-1:0] exp_v [4];
        int w0, e0, h0, d0;
        bit ok;
        ez_v  = '{32'd0, 32'd1, 32'd3, 32'd6, 32'd10};
        exp_v = '{32'd1, 32'd2, 32'd3, 32'd4};
        for (int i = 0; i < 5; i++) begin ez_mem[i] = ez_v[i]; hy_mem[i] = 32'd0; end
        w0 = wq_addr.size(); e0 = ezq.size(); h0 = hrd_cnt; d0 = done_cnt;
        kick(4);
        vectors++;
        if (busy_o !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b required 1", busy_o); end
        wait_done(d0, 60, ok);
        repeat (3) tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_timeout: done not seen within 60 cycles"); end
        vectors++;
        if (wq_addr.size() - w0 != 4) begin
            miscompares++; $display("FAIL basic_wr_count: got %0d required 4", wq_addr.size() - w0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                vectors++;
                if (wq_addr[w0+j] !== AW'(j) || wq_data[w0+j] !== exp_v[j]) begin
                    miscompares++;
                    $display("FAIL basic_write[%0d]: got addr %0d data %0d required addr %0d data %0d",
                             j, wq_addr[w0+j], wq_data[w0+j], j, exp_v[j]);
                end
            end
            vectors++;
            if (wq_cyc[w0] - start_cyc != FIRST_WR) begin
                miscompares++;
                $display("FAIL first_write_latency: got %0d required %0d", wq_cyc[w0] - start_cyc, FIRST_WR);
            end
            vectors++;
            if (wq_cyc[w0+3] - wq_cyc[w0] != 3) begin
                miscompares++;
                $display("FAIL write_burst: span %0d required 3", wq_cyc[w0+3] - wq_cyc[w0]);
            end
        end
        vectors++;
        if (done_cnt - d0 != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
        vectors++;
        if (ezq.size() - e0 != 5 || hrd_cnt - h0 != 4) begin
            miscompares++;
            $display("FAIL basic_read_count: ez %0d hy %0d required ez 5 hy 4", ezq.size() - e0, hrd_cnt - h0);
        end
    endtask

    task automatic test_zero();
        int w0, e0, h0, d0, b0;
        w0 = wq_addr.size(); e0 = ezq.size(); h0 = hrd_cnt; d0 = done_cnt; b0 = busy_cnt;
        kick(0);
        vectors++;
        if (done_o !== 1'b1) begin miscompares++; $display("FAIL zero_done_timing: got %b required 1", done_o); end
        repeat (4) tick();
        vectors++;
        if (wq_addr.size() != w0 || ezq.size() != e0 || hrd_cnt != h0 || busy_cnt != b0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL zero_pass: wr %0d ezrd %0d hyrd %0d busy %0d done %0d required 0 0 0 0 1",
                     wq_addr.size() - w0, ezq.size() - e0, hrd_cnt - h0, busy_cnt - b0, done_cnt - d0);
        end
    endtask

    task automatic test_restart_ignored();
        int w0, d0, n;
        bit ok;
        n = 6;
        fill_random(n);
        w0 = wq_addr.size(); d0 = done_cnt;
        kick(n);
        repeat (3) tick();
        start_i = 1'b1; n_cells_i = AW'(9);
        tick();
        start_i = 1'b0;
        wait_done(d0, 80, ok);
        repeat (3) tick();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL restart_timeout: done not seen"); end
        vectors++;
        if (wq_addr.size() - w0 != n || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL restart_counts: writes %0d done %0d required %0d 1", wq_addr.size() - w0, done_cnt - d0, n);
        end else begin
            for (int j = 0; j < n; j++) begin
                vectors++;
                if (wq_addr[w0+j] !== AW'(j) || wq_data[w0+j] !== model_hy(j)) begin
                    miscompares++;
                    $display("FAIL restart_write[%0d]: got %0d/%h required %0d/%h", j, wq_addr[w0+j], wq_data[w0+j], j, model_hy(j));
                end
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int w0, d0, n;
        bit ok;
        fill_random(8);
        d0 = done_cnt;
        kick(8);
        repeat (4) tick();
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if (any_out() !== 1'b0) begin miscompares++; $display("FAIL midreset_outputs: or=%b required 0", any_out()); end
        w0 = wq_addr.size();
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (20) tick();
        vectors++;
        if (wq_addr.size() != w0 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL midreset_aborted: writes %0d done %0d required 0 0", wq_addr.size() - w0, done_cnt - d0);
        end
        n = 3;
        fill_random(n);
        w0 = wq_addr.size(); d0 = done_cnt;
        kick(n);
        wait_done(d0, 60, ok);
        vectors++;
        if (!ok || wq_addr.size() - w0 != n) begin
            miscompares++;
            $display("FAIL midreset_recover_count: done %b writes %0d required 1 %0d", ok, wq_addr.size() - w0, n);
        end else begin
            for (int j = 0; j < n; j++) begin
                vectors++;
                if (wq_addr[w0+j] !== AW'(j) || wq_data[w0+j] !== model_hy(j)) begin
                    miscompares++;
                    $display("FAIL midreset_recover[%0d]: got %0d/%h required %0d/%h", j, wq_addr[w0+j], wq_data[w0+j], j, model_hy(j));
                end
            end
        end
    endtask

    task automatic test_max_n();
        int w0, e0, h0, d0, bad;
        bit ok;
        for (int i = 0; i <= NMAX; i++) begin ez_mem[i] = DW'(i); hy_mem[i] = $urandom; end
        w0 = wq_addr.size(); e0 = ezq.size(); h0 = hrd_cnt; d0 = done_cnt;
        kick(NMAX);
        wait_done(d0, NMAX + 100, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL max_timeout: done not seen"); end
        vectors++;
        if (wq_addr.size() - w0 != NMAX || hrd_cnt - h0 != NMAX) begin
            miscompares++;
            $display("FAIL max_counts: writes %0d hyrd %0d required %0d", wq_addr.size() - w0, hrd_cnt - h0, NMAX);
        end else begin
            bad = 0;
            for (int j = 0; j < NMAX; j++) begin
                if (wq_addr[w0+j] !== AW'(j) || wq_data[w0+j] !== hy_mem[j] + 32'd1) bad++;
            end
            vectors++;
            if (bad != 0) begin miscompares++; $display("FAIL max_writes: %0d bad writes required 0", bad); end
        end
        vectors++;
        if (ezq.size() - e0 != NMAX + 1) begin
            miscompares++;
            $display("FAIL max_ez_reads: got %0d required %0d", ezq.size() - e0, NMAX + 1);
        end else begin
            bad = 0;
            for (int j = 0; j <= NMAX; j++) if (ezq[e0+j] !== AW'(j)) bad++;
            vectors++;
            if (bad != 0 || ezq[e0+NMAX] !== AW'(NMAX)) begin
                miscompares++;
                $display("FAIL max_ez_sequence: %0d out of order, last %0d required last %0d", bad, ezq[e0+NMAX], NMAX);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int w0, d0, n;
        bit ok;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 40);
            fill_random(n);
            w0 = wq_addr.size(); d0 = done_cnt;
            kick(n);
            wait_done(d0, n + 60, ok);
            vectors++;
            if (!ok || wq_addr.size() - w0 != n) begin
                miscompares++;
                $display("FAIL rand%0d_count: done %b writes %0d required 1 %0d", it, ok, wq_addr.size() - w0, n);
            end else begin
                for (int j = 0; j < n; j++) begin
                    vectors++;
                    if (wq_addr[w0+j] !== AW'(j) || wq_data[w0+j] !== model_hy(j)) begin
                        miscompares++;
                        $display("FAIL rand%0d_write[%0d]: got %0d/%h required %0d/%h", it, j, wq_addr[w0+j], wq_data[w0+j], j, model_hy(j));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_restart_ignored();
        test_reset_mid_pass();
        test_back_to_back_random();
        test_max_n();
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
